// File: rtl/rect_fill_pkg.sv
// Shared definitions for the rectangle-fill Avalon engine.
//   state_t      : engine FSM states (IDLE / RUN)
//   REG_*        : CPU slave word offsets
//   SCREEN_W/H   : visible raster size; X_MAX/Y_MAX are the last valid coords
//   pack_pixel() : builds the plotter word {0, y[6:0], x[7:0], 8'h00, colour}
package rect_fill_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_P0     = 4'd1;
  localparam logic [3:0] REG_P1     = 4'd2;
  localparam logic [3:0] REG_COLOUR = 4'd3;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam logic [7:0] X_MAX = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - 1);

  function automatic logic [31:0] pack_pixel(input logic [7:0] x,
                                             input logic [6:0] y,
                                             input logic [7:0] colour);
    return {1'b0, y, x, 8'h00, colour};
  endfunction

endpackage

// File: rtl/rect_fill_avalon_rect_scan.sv
// Raster scan counters for one rectangle fill.
//   clk, reset_n : clock, async active-low reset
//   load         : capture start point and (already clamped) end point
//   advance      : current pixel accepted; step to the next one
//   x0,y0,x1,y1  : rectangle corners, x1/y1 inclusive
//   x, y         : current pixel coordinate
//   last         : current pixel is the final one of the rectangle
module rect_scan
  import rect_fill_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic       last
);

  logic [7:0] x_start;
  logic [7:0] x_end;
  logic [6:0] y_end;

  assign last = (x == x_end) && (y == y_end);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x       <= '0;
      y       <= '0;
      x_start <= '0;
      x_end   <= '0;
      y_end   <= '0;
    end else if (load) begin
      x       <= x0;
      y       <= y0;
      x_start <= x0;
      x_end   <= x1;
      y_end   <= y1;
    end else if (advance && !last) begin
      if (x == x_end) begin
        x <= x_start;
        y <= y + 7'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rect_fill_avalon.sv
// Rectangle fill engine: CPU-programmed rectangle is streamed as one pixel
// write per accepted Avalon master transfer to a VGA plotter slave.
//   clk, reset_n          : clock, async active-low reset
//   address/read/readdata : CPU slave, zero read latency
//   write/writedata       : CPU slave writes (0 = start, 1 = P0, 2 = P1, 3 = colour)
//   master_address        : fixed VGA_ADDR
//   master_write          : high throughout a fill
//   master_writedata      : current pixel word, held while stalled
//   master_waitrequest    : downstream stall
module rect_fill_avalon
  import rect_fill_pkg::*;
#(
  parameter logic [31:0] VGA_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  address,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] master_address,
  output logic        master_write,
  output logic [31:0] master_writedata,
  input  logic        master_waitrequest
);

  state_t     state;
  logic       done_q;
  logic [7:0] x0_q;
  logic [6:0] y0_q;
  logic [7:0] x1_q;
  logic [6:0] y1_q;
  logic [7:0] colour_q;

  logic [7:0] x1_eff;
  logic [6:0] y1_eff;
  logic       range_ok;
  logic       busy;
  logic       start_ok;
  logic       accept;
  logic [7:0] scan_x;
  logic [6:0] scan_y;
  logic       scan_last;

  logic unused_wdata;
  assign unused_wdata = ^{writedata[31], writedata[15:8]};

  assign x1_eff   = (x1_q > X_MAX) ? X_MAX : x1_q;
  assign y1_eff   = (y1_q > Y_MAX) ? Y_MAX : y1_q;
  assign range_ok = (x0_q <= X_MAX) && (y0_q <= Y_MAX) &&
                    (x0_q <= x1_eff) && (y0_q <= y1_eff);

  assign busy     = (state == ST_RUN);
  assign start_ok = (state == ST_IDLE) && write && (address == REG_CTRL) && range_ok;
  assign accept   = busy && !master_waitrequest;

  assign master_address   = VGA_ADDR;
  assign master_write     = busy;
  // Colour cannot change while busy, so the word is stable across stalls.
  assign master_writedata = pack_pixel(scan_x, scan_y, colour_q);

  rect_scan u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (start_ok),
    .advance (accept),
    .x0      (x0_q),
    .y0      (y0_q),
    .x1      (x1_eff),
    .y1      (y1_eff),
    .x       (scan_x),
    .y       (scan_y),
    .last    (scan_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      done_q   <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
    end else if (state == ST_IDLE) begin
      if (write) begin
        case (address)
          // An empty/off-screen rectangle completes at once: done without RUN.
          REG_CTRL: begin
            done_q <= !range_ok;
            if (range_ok) state <= ST_RUN;
          end
          REG_P0: begin
            x0_q <= writedata[23:16];
            y0_q <= writedata[30:24];
          end
          REG_P1: begin
            x1_q <= writedata[23:16];
            y1_q <= writedata[30:24];
          end
          REG_COLOUR: colour_q <= writedata[7:0];
          default: ;
        endcase
      end
    end else if (accept && scan_last) begin
      state  <= ST_IDLE;
      done_q <= 1'b1;
    end
  end

  always_comb begin
    readdata = '0;
    if (read) begin
      case (address)
        REG_CTRL:   readdata = {30'd0, done_q, busy};
        REG_P0:     readdata = {1'b0, y0_q, x0_q, 16'h0000};
        REG_P1:     readdata = {1'b0, y1_q, x1_q, 16'h0000};
        REG_COLOUR: readdata = {24'd0, colour_q};
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_avalon.sv
module tb_rect_fill_avalon;

  localparam logic [31:0] VGA = 32'h0800_0040;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  address = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest = 1'b0;

  rect_fill_avalon #(.VGA_ADDR(VGA)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .address            (address),
    .read               (read),
    .readdata           (readdata),
    .write              (write),
    .writedata          (writedata),
    .master_address     (master_address),
    .master_write       (master_write),
    .master_writedata   (master_writedata),
    .master_waitrequest (master_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];
  int mw_cycles = 0;
  int hold_b = 0;
  int stall_mode = 0;
  int stall_ctr = 0;
  int pops = 0;

  int m_x0 = 0, m_y0 = 0, m_x1 = 0, m_y1 = 0, m_col = 0;
  logic m_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: list every pixel of the clamped rectangle in raster order.
  task automatic model_start();
    int xe, ye;
    xe = (m_x1 > 159) ? 159 : m_x1;
    ye = (m_y1 > 119) ? 119 : m_y1;
    m_done = 1'b0;
    if (m_x0 > 159 || m_y0 > 119 || m_x0 > xe || m_y0 > ye) begin
      m_done = 1'b1;
    end else begin
      for (int y = m_y0; y <= ye; y++)
        for (int x = m_x0; x <= xe; x++)
          exp_q.push_back({1'b0, y[6:0], x[7:0], 8'h00, m_col[7:0]});
    end
  endtask

  // Per-cycle output check and acceptance tracking.
  always @(negedge clk) begin
    check("master_write", 32'(master_write), 32'(exp_q.size() != 0));
    check("master_address", master_address, VGA);
    if (master_write && exp_q.size() != 0) begin
      check("pixel_word", master_writedata, exp_q[0]);
      mw_cycles++;
      if (master_writedata == 32'h050B0080) hold_b++;
    end
    case (stall_mode)
      1: master_waitrequest = ($urandom_range(0, 3) == 0);
      2: if (pops == 1 && stall_ctr < 3) begin
           master_waitrequest = 1'b1;
           stall_ctr++;
         end else begin
           master_waitrequest = 1'b0;
         end
      default: master_waitrequest = 1'b0;
    endcase
    if (master_write && reset_n && exp_q.size() != 0 && !master_waitrequest) begin
      acc_log.push_back(master_writedata);
      void'(exp_q.pop_front());
      pops++;
    end
  end

  task automatic cpu_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    address = addr;
    writedata = data;
    write = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    if (exp_q.size() == 0) begin
      case (addr)
        4'd0: model_start();
        4'd1: begin m_x0 = int'(data[23:16]); m_y0 = int'(data[30:24]); end
        4'd2: begin m_x1 = int'(data[23:16]); m_y1 = int'(data[30:24]); end
        4'd3: m_col = int'(data[7:0]);
        default: ;
      endcase
    end
  endtask

  task automatic cpu_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    address = addr;
    read = 1'b1;
    #1;
    data = readdata;
    read = 1'b0;
  endtask

  function automatic logic [31:0] pt(input int x, input int y);
    return {1'b0, y[6:0], x[7:0], 16'h0000};
  endfunction

  task automatic wait_idle(input int max_cycles);
    int n;
    logic [31:0] st;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    check("fill_completes_in_budget", 32'(n < max_cycles), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    m_done = 1'b1;
    cpu_read(4'd0, st);
    check("status_after_fill", st, {30'd0, m_done, 1'b0});
  endtask

  task automatic setup(input int x0, input int y0, input int x1, input int y1, input int col);
    cpu_write(4'd1, pt(x0, y0));
    cpu_write(4'd2, pt(x1, y1));
    cpu_write(4'd3, 32'(col));
  endtask

  initial begin
    logic [31:0] rd;
    int n, n_exp;
    int x0, y0, x1, y1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_master_write", 32'(master_write), 32'd0);
    check("reset_writedata", master_writedata, 32'd0);
    cpu_read(4'd0, rd);
    check("reset_status", rd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic 2x2 fill, no stalls
    stall_mode = 0;
    setup(10, 5, 11, 6, 8'h80);
    cpu_read(4'd1, rd);
    check("p0_readback", rd, 32'h050A_0000);
    cpu_read(4'd3, rd);
    check("colour_readback", rd, 32'h0000_0080);
    cpu_read(4'd5, rd);
    check("unmapped_read", rd, 32'd0);
    acc_log.delete(); mw_cycles = 0; hold_b = 0;
    cpu_write(4'd0, 32'd0);
    cpu_read(4'd0, rd);
    check("status_busy", rd, 32'd1);
    wait_idle(100);
    check("basic_count", 32'(acc_log.size()), 32'd4);
    check("basic_mw_cycles", 32'(mw_cycles), 32'd4);
    if (acc_log.size() == 4) begin
      check("basic_w0", acc_log[0], 32'h050A0080);
      check("basic_w1", acc_log[1], 32'h050B0080);
      check("basic_w2", acc_log[2], 32'h060A0080);
      check("basic_w3", acc_log[3], 32'h060B0080);
    end

    // Same fill, second pixel stalled 3 cycles
    stall_mode = 2; stall_ctr = 0; pops = 0;
    acc_log.delete(); mw_cycles = 0; hold_b = 0;
    cpu_write(4'd0, 32'd0);
    wait_idle(100);
    check("stall_count", 32'(acc_log.size()), 32'd4);
    check("stall_mw_cycles", 32'(mw_cycles), 32'd7);
    check("stall_hold_cycles", 32'(hold_b), 32'd4);
    if (acc_log.size() == 4) begin
      check("stall_w1", acc_log[1], 32'h050B0080);
      check("stall_w2", acc_log[2], 32'h060A0080);
    end

    // Clamped at the bottom-right corner
    stall_mode = 0;
    setup(158, 119, 200, 127, 8'h3C);
    acc_log.delete();
    cpu_write(4'd0, 32'd0);
    wait_idle(100);
    check("clamp_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() == 2) begin
      check("clamp_w0", acc_log[0], 32'h779E003C);
      check("clamp_w1", acc_log[1], 32'h779F003C);
    end

    // Empty rectangle: no writes, done one cycle later
    setup(20, 0, 10, 0, 8'h11);
    acc_log.delete(); mw_cycles = 0;
    cpu_write(4'd0, 32'd0);
    cpu_read(4'd0, rd);
    check("empty_status", rd, 32'd2);
    repeat (3) @(posedge clk);
    check("empty_count", 32'(mw_cycles), 32'd0);

    // 10x10 fill with ignored writes mid-run
    stall_mode = 1;
    setup(30, 40, 39, 49, 8'h55);
    acc_log.delete();
    cpu_write(4'd0, 32'd0);
    repeat (5) @(posedge clk);
    cpu_write(4'd1, pt(0, 0));
    cpu_write(4'd0, 32'd0);
    cpu_write(4'd3, 32'h0000_00AA);
    wait_idle(1000);
    check("busy_fill_count", 32'(acc_log.size()), 32'd100);
    cpu_read(4'd1, rd);
    check("p0_kept_while_busy", rd, pt(30, 40));
    cpu_read(4'd3, rd);
    check("colour_kept_while_busy", rd, 32'h0000_0055);

    // Reset after write 37 of a second fill
    acc_log.delete();
    cpu_write(4'd0, 32'd0);
    n = 0;
    while (acc_log.size() < 37 && n < 1000) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("reach_write_37", 32'(n < 1000), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_aborts_write", 32'(master_write), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0; m_col = 0; m_done = 1'b0;
    repeat (5) @(posedge clk);
    check("reset_write_total", 32'(acc_log.size()), 32'd37);
    cpu_read(4'd0, rd);
    check("status_after_reset", rd, 32'd0);
    cpu_read(4'd1, rd);
    check("p0_after_reset", rd, 32'd0);

    // Randomized rectangles, including clamped and empty ones
    for (int it = 0; it < 14; it++) begin
      stall_mode = int'($urandom_range(0, 1));
      x0 = int'($urandom_range(0, 165));
      y0 = int'($urandom_range(0, 124));
      if ($urandom_range(0, 3) == 0) x1 = int'($urandom_range(150, 255));
      else x1 = x0 + int'($urandom_range(0, 12)) - 2;
      y1 = y0 + int'($urandom_range(0, 10)) - 2;
      if (x1 < 0) x1 = 0;
      if (x1 > 255) x1 = 255;
      if (y1 < 0) y1 = 0;
      if (y1 > 127) y1 = 127;
      setup(x0, y0, x1, y1, int'($urandom_range(0, 255)));
      acc_log.delete();
      cpu_write(4'd0, 32'd0);
      n_exp = exp_q.size();
      wait_idle(6000);
      check("random_count", 32'(acc_log.size()), 32'(n_exp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
